serdes_serializer: RTL and testbench

- Transmit-side front end of the SerDes: accepts parallel words over a valid/ready handshake and shifts each one out as a framed, LSB-first serial bitstream on a single line.
- Frame: start bit (0), DATA_W data bits, optional parity bit, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits directly upstream of the deserializer; its ser_out is the deserializer's serial input.

---
 rtl/serdes_pkg.sv | 20 ++
 rtl/serdes_bit_timer.sv | 27 ++
 rtl/serdes_serializer.sv | 115 +++++++++++
 tb/tb_serdes_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Types and constants shared by the SerDes serializer and deserializer.
package serdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input bit parity_en);
    return data_w + 2 + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/serdes_bit_timer.sv
// Bit-period timer: bit_tick marks the last clock of each serial bit while run is high.
module serdes_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // With CLKS_PER_BIT=1 LAST is zero, so cnt stays at 0 and every running cycle ticks.
  always_ff @(posedge clk) begin
    if (rst || !run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/serdes_serializer.sv
// Framed LSB-first parallel-to-serial transmitter with valid/ready input.
// Optional even parity bit enabled by defining SERDES_SER_PARITY_EN.
module serdes_serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  ser_state_t        state;
  ser_state_t        state_nx;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nx;
  logic [DATA_W-1:0] data_q;
  logic              bit_tick;
  logic              accept;
  logic              line_nx;
  logic              run;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign run      = (state != IDLE);

  serdes_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        if (bit_tick) begin
          state_nx = DATA;
          idx_nx   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == LAST_IDX) begin
`ifdef SERDES_SER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
`ifdef SERDES_SER_PARITY_EN
      PARITY: begin
        if (bit_tick) state_nx = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is decoded from the next state so ser_out can be a plain register.
  always_comb begin
    line_nx = LINE_IDLE;
    case (state_nx)
      START:   line_nx = START_BIT;
      DATA:    line_nx = data_q[idx_nx];
`ifdef SERDES_SER_PARITY_EN
      PARITY:  line_nx = ^data_q;
`endif
      default: line_nx = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      data_q     <= '0;
      ser_out    <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      if (accept) data_q <= in_data;
      ser_out    <= line_nx;
      busy       <= (state_nx != IDLE);
      frame_done <= (state == STOP) && bit_tick;
    end
  end

endmodule

// File: tb/tb_serdes_serializer.sv
// Scoreboard bench for serdes_serializer (DATA_W=8, CLKS_PER_BIT=4), both parity builds.
module tb_serdes_serializer;
  import serdes_pkg::*;

  localparam int DW = 8;
  localparam int CPB = 4;
`ifdef SERDES_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB   = frame_bits(DW, PAR);
  localparam int FLEN = FB * CPB;

  typedef struct packed {
    logic ser;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ser_out;
  logic          busy;
  logic          frame_done;

  exp_t sb[$];
  int   acc_cyc[$];
  int   npass  = 0;
  int   ntotal = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  serdes_serializer #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs for one frame, starting the cycle after accept.
  function automatic void push_frame(input logic [DW-1:0] w);
    logic b;
    exp_t e;
    for (int i = 0; i < FB; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= DW) b = w[i-1];
      else if (PAR && i == DW + 1) b = ^w;
      else b = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        e = '{ser: b, busy: 1'b1, done: 1'b0, rdy: 1'b0};
        sb.push_back(e);
      end
    end
    e = '{ser: 1'b1, busy: 1'b0, done: 1'b1, rdy: 1'b1};
    sb.push_back(e);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      push_frame(in_data);
      acc_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      exp_t act;
      act = '{ser: ser_out, busy: busy, done: frame_done, rdy: in_ready};
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{ser: 1'b1, busy: 1'b0, done: 1'b0, rdy: !rst};
      ntotal++;
      if (act !== e)
        $display("FAIL sb_cycle%0d got ser=%b busy=%b done=%b rdy=%b expected ser=%b busy=%b done=%b rdy=%b",
                 cyc, act.ser, act.busy, act.done, act.rdy, e.ser, e.busy, e.done, e.rdy);
      else npass++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    ntotal++;
    if (n >= 200) $display("FAIL send_accept got no in_ready expected accept of %h", w);
    else npass++;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    ntotal++;
    if (n >= 400) $display("FAIL wait_idle got busy=%b queued=%0d expected idle", busy, sb.size());
    else npass++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    ntotal += 4;
    if (ser_out !== 1'b1) $display("FAIL reset_ser got %b expected 1", ser_out); else npass++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else npass++;
    if (frame_done !== 1'b0) $display("FAIL reset_done got %b expected 0", frame_done); else npass++;
    if (in_ready !== 1'b0) $display("FAIL reset_rdy_in_rst got %b expected 0", in_ready); else npass++;
    rst = 1'b0;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL reset_rdy_after got %b expected 1", in_ready); else npass++;
    mon_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int nb = 0;
    send(8'hA5, 1'b0);
    while (nb < 200) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    ntotal += 2;
    if (nb != FLEN) $display("FAIL single_busy_len got %0d expected %0d", nb, FLEN); else npass++;
    if (frame_done !== 1'b1) $display("FAIL single_done got %b expected 1", frame_done); else npass++;
    wait_idle();
  endtask

  task automatic test_parity();
    logic [DW-1:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      int nb = 0;
      logic exp_b;
      exp_b = PAR ? ^words[k] : 1'b1;
      send(words[k], 1'b0);
      while (nb < 200) begin
        @(negedge clk);
        if (!busy) break;
        nb++;
        if (nb == (DW + 1) * CPB + 2) begin
          ntotal++;
          if (ser_out !== exp_b) $display("FAIL parity_bit_%h got %b expected %b", words[k], ser_out, exp_b);
          else npass++;
        end
      end
      ntotal++;
      if (nb != FLEN) $display("FAIL parity_len_%h got %0d expected %0d", words[k], nb, FLEN); else npass++;
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    int base = acc_cyc.size();
    int n = 0;
    send(8'h3C, 1'b1);
    in_data = 8'hC3;
    while (acc_cyc.size() < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    ntotal++;
    if (acc_cyc.size() < base + 2) $display("FAIL b2b_second_accept got none expected accept");
    else begin
      if (acc_cyc[base+1] - acc_cyc[base] != FLEN + 1)
        $display("FAIL b2b_gap got %0d expected %0d", acc_cyc[base+1] - acc_cyc[base], FLEN + 1);
      else npass++;
    end
    wait_idle();
  endtask

  task automatic test_ignore();
    int base = acc_cyc.size();
    send(8'h5A, 1'b1);
    repeat (30) begin
      tick();
      in_data = DW'($urandom);
    end
    in_valid = 1'b0;
    ntotal++;
    if (acc_cyc.size() != base + 1) $display("FAIL ignore_accepts got %0d expected %0d", acc_cyc.size() - base, 1);
    else npass++;
    wait_idle();
  endtask

  task automatic test_mid_reset();
    int nd = 0;
    send(8'h96, 1'b0);
    repeat (16) tick();
    rst = 1'b1;
    #1;
    ntotal++;
    if (in_ready !== 1'b0) $display("FAIL midrst_rdy got %b expected 0", in_ready); else npass++;
    tick();
    rst = 1'b0;
    ntotal += 3;
    if (ser_out !== 1'b1) $display("FAIL midrst_ser got %b expected 1", ser_out); else npass++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b expected 0", busy); else npass++;
    if (frame_done !== 1'b0) $display("FAIL midrst_done got %b expected 0", frame_done); else npass++;
    repeat (50) begin
      @(negedge clk);
      if (frame_done) nd++;
    end
    ntotal++;
    if (nd != 0) $display("FAIL midrst_no_done got %0d pulses expected 0", nd); else npass++;
    send(8'h5A, 1'b0);
    wait_idle();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_ignore();
    test_mid_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
